breath_ctrl: RTL
================

Name: breath_ctrl

Overview:
- Multi-channel LED breathing/fade controller. Generalises the single-channel triangle ramp into N channels with selectable mode, programmable step, peak/trough hold and a fixed per-channel phase stagger.
- Runs on the 1 ms tick clock from the existing divider.
- Each duty output drives one instance of the existing pwm block.

Parameters:
- CHANNELS, 4, number of independent duty outputs.
- BITS, 10, duty width per channel.
- RANGE, 999, maximum duty value; requires RANGE < 2**BITS.
- STEP_W, 4, width of the step input.
- HOLD_W, 8, width of the hold input.
- STAGGER, 100, start delay in ticks between adjacent channels.

Ports:
- clk1ms  in  1  1 ms tick clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  1 = run; 0 = freeze all state and outputs.
- mode  in  2  0 OFF, 1 ON, 2 BREATHE, 3 BLINK; global to all channels.
- step  in  STEP_W  duty increment per tick in BREATHE; 0 is treated as 1.
- hold  in  HOLD_W  dwell ticks at peak/trough (BREATHE) or half-period-1 (BLINK).
- duty  out  CHANNELS*BITS  packed duties; channel i occupies bits [i*BITS +: BITS].
- cycle_done  out  CHANNELS  one-tick pulse when a channel completes a full breathe or blink period.

Behaviour:
- "Tick" means a clk1ms rising edge with rst=1.

Reset (rst=0):
- All duty = 0, cycle_done = 0.
- Channel i enters WAIT with counter i*STAGGER.
- Registered previous mode = 2.

Mode-change restart:
- When en=1 and mode differs from the registered previous mode, every channel re-initialises exactly as after reset (duty 0, WAIT, stagger reloaded) on that tick.
- The previous-mode register then updates.
- Mode changes while en=0 take effect on the first tick with en=1.

en=0:
- No register changes.
- cycle_done forced to 0.

OFF mode:
- duty = 0.
- Channel held in WAIT with counter frozen at its reload value.

ON mode:
- duty = RANGE.
- Channel held in WAIT with counter frozen at its reload value.

BREATHE, per-channel FSM (WAIT, RISE, HOLD_HI, FALL, HOLD_LO):
- WAIT: while the counter is nonzero, decrement it. When the counter is 0, the same tick moves to RISE and applies the first step. Consequence: channel i first shows duty = step at tick i*STAGGER+1.
- RISE: duty += s, where s = max(step,1). If duty+s >= RANGE, duty = RANGE (saturate) and the channel goes to HOLD_HI; if hold = 0 it goes directly to FALL.
- HOLD_HI: stays exactly hold ticks, then FALL.
- FALL: duty -= s. If duty <= s, duty = 0, cycle_done pulses on that tick, and the channel goes to HOLD_LO (or RISE if hold = 0).
- HOLD_LO: stays hold ticks, then RISE.
- Arithmetic uses a BITS+1 wide intermediate: no wrap below 0, no overflow above RANGE.

BLINK:
- After WAIT, duty alternates RANGE / 0.
- Each level lasts hold+1 ticks; the first level is RANGE.
- cycle_done pulses on the tick duty returns to 0.

Live inputs:
- step and hold are sampled every tick.
- A changed hold applies to the next hold count started; a hold in progress compares against the live value, and a counter already >= hold exits immediately.

Latency:
- Outputs are registered.
- One tick from input or state change to duty update.

Decomposition:
- Package breath_pkg: mode encodings (MODE_OFF, MODE_ON, MODE_BREATHE, MODE_BLINK) and the channel state enum (WAIT, RISE, HOLD_HI, FALL, HOLD_LO).
- Sub-module breath_chan: one channel FSM with duty, hold counter and stagger counter. Its stagger reload is a parameter set to i*STAGGER.
- breath_ctrl: instantiates CHANNELS copies via generate and owns the previous-mode register and restart pulse.

Test Plan:
Defaults, step=1, hold=0, mode=2 throughout unless stated.
- Reset release with en=1 -> ch0 duty=1 at tick 1, 999 at tick 999, 998 at tick 1000, 0 at tick 1998 with cycle_done[0]=1 on that tick only; ch1 duty=1 at tick 101; ch3 first nonzero at tick 301.
- step=7, hold=5 -> ch0 duty 7,14,…,994 then saturates at 999 (tick 143); holds 999 for ticks 144–148; tick 149 duty=992; falls to 0 without wrap (5 -> 0).
- step=0 -> behaves identically to step=1.
- Mode 3, hold=2 -> ch0 duty 999 for 3 ticks, 0 for 3 ticks, repeating; cycle_done[0] pulses on each 999->0 tick; ch2 starts 200 ticks later.
- Mid-ramp (ch0 duty=500), set en=0 for 50 ticks -> all duty and FSM state frozen, cycle_done=0; resume continues at 501.
- Mid-ramp, switch mode 2->0 -> next tick all duty=0; switch back to 2 -> stagger restart, ch0 duty=1 one tick later. Assert rst mid-ramp -> duty=0 immediately (asynchronous), with no clock edge needed.

Source files
------------

// File: rtl/breath_pkg.sv
// Shared definitions for the multi-channel LED breathing controller:
// global mode encodings and the per-channel state machine states.
package breath_pkg;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ON      = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_BLINK   = 2'd3;

    typedef enum logic [2:0] {
        WAIT,
        RISE,
        HOLD_HI,
        FALL,
        HOLD_LO
    } chan_state_t;

endpackage

// File: rtl/breath_chan.sv
// One breathing/blink channel: stagger delay, triangle ramp with peak/trough
// dwell, or square blink, all advancing once per 1 ms tick.
module breath_chan
    import breath_pkg::*;
#(
    parameter int BITS   = 10,
    parameter int RANGE  = 999,
    parameter int STEP_W = 4,
    parameter int HOLD_W = 8,
    parameter int RELOAD = 0
) (
    input  logic              clk1ms,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [HOLD_W-1:0] hold,
    output logic [BITS-1:0]   duty,
    output logic              cycle_done
);

    localparam int WAIT_W = (RELOAD > 0) ? $clog2(RELOAD + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RELOAD);
    localparam logic [BITS:0]     RANGE_X   = (BITS + 1)'(RANGE);
    localparam logic [BITS-1:0]   RANGE_B   = BITS'(RANGE);

    chan_state_t       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [HOLD_W-1:0] hcnt;
    logic              done_q;

    logic [BITS:0]   step_x;
    logic [BITS:0]   duty_x;
    logic [BITS:0]   rise_sum;
    logic [BITS:0]   fall_diff;
    logic [HOLD_W:0] hcnt_inc;
    logic [HOLD_W:0] hcnt_x;
    logic [HOLD_W:0] hold_x;
    logic            rise_sat;
    logic            fall_end;
    logic            hold_zero;
    logic            waiting;

    // One bit of headroom keeps the ramp from wrapping at either end.
    assign step_x    = (step == '0) ? (BITS + 1)'(1) : (BITS + 1)'(step);
    assign duty_x    = {1'b0, duty};
    assign rise_sum  = duty_x + step_x;
    assign fall_diff = duty_x - step_x;
    assign rise_sat  = rise_sum >= RANGE_X;
    assign fall_end  = duty_x <= step_x;
    assign hcnt_x    = {1'b0, hcnt};
    assign hcnt_inc  = hcnt_x + (HOLD_W + 1)'(1);
    assign hold_x    = {1'b0, hold};
    assign hold_zero = hold == '0;
    assign waiting   = (state == WAIT) && (wait_cnt != '0);

    assign cycle_done = done_q & en;

    always_ff @(posedge clk1ms or negedge rst) begin
        if (!rst) begin
            state    <= WAIT;
            wait_cnt <= WAIT_INIT;
            hcnt     <= '0;
            duty     <= '0;
            done_q   <= 1'b0;
        end else if (en) begin
            done_q <= 1'b0;
            if (restart || mode == MODE_OFF || mode == MODE_ON) begin
                state    <= WAIT;
                wait_cnt <= WAIT_INIT;
                hcnt     <= '0;
                duty     <= (!restart && mode == MODE_ON) ? RANGE_B : '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end else if (mode == MODE_BREATHE) begin
                case (state)
                    WAIT, RISE: begin
                        if (rise_sat) begin
                            duty  <= RANGE_B;
                            hcnt  <= '0;
                            state <= hold_zero ? FALL : HOLD_HI;
                        end else begin
                            duty  <= rise_sum[BITS-1:0];
                            state <= RISE;
                        end
                    end
                    HOLD_HI: begin
                        if (hcnt_inc >= hold_x) begin
                            hcnt  <= '0;
                            state <= FALL;
                        end else begin
                            hcnt <= hcnt_inc[HOLD_W-1:0];
                        end
                    end
                    FALL: begin
                        if (fall_end) begin
                            duty   <= '0;
                            done_q <= 1'b1;
                            hcnt   <= '0;
                            state  <= hold_zero ? RISE : HOLD_LO;
                        end else begin
                            duty <= fall_diff[BITS-1:0];
                        end
                    end
                    HOLD_LO: begin
                        if (hcnt_inc >= hold_x) begin
                            hcnt  <= '0;
                            state <= RISE;
                        end else begin
                            hcnt <= hcnt_inc[HOLD_W-1:0];
                        end
                    end
                    default: state <= WAIT;
                endcase
            end else begin
                // Blink reuses the hold states as its high and low half-periods.
                case (state)
                    HOLD_HI: begin
                        if (hcnt_x >= hold_x) begin
                            duty   <= '0;
                            done_q <= 1'b1;
                            hcnt   <= '0;
                            state  <= HOLD_LO;
                        end else begin
                            hcnt <= hcnt_inc[HOLD_W-1:0];
                        end
                    end
                    HOLD_LO: begin
                        if (hcnt_x >= hold_x) begin
                            duty  <= RANGE_B;
                            hcnt  <= '0;
                            state <= HOLD_HI;
                        end else begin
                            hcnt <= hcnt_inc[HOLD_W-1:0];
                        end
                    end
                    default: begin
                        duty  <= RANGE_B;
                        hcnt  <= '0;
                        state <= HOLD_HI;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/breath_ctrl.sv
// Multi-channel LED breathing controller: staggered channel instances plus
// the previous-mode register that restarts every channel on a mode change.
module breath_ctrl
    import breath_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int BITS     = 10,
    parameter int RANGE    = 999,
    parameter int STEP_W   = 4,
    parameter int HOLD_W   = 8,
    parameter int STAGGER  = 100
) (
    input  logic                     clk1ms,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [STEP_W-1:0]        step,
    input  logic [HOLD_W-1:0]        hold,
    output logic [CHANNELS*BITS-1:0] duty,
    output logic [CHANNELS-1:0]      cycle_done
);

    logic [1:0] prev_mode;
    logic       restart;

    assign restart = en && (mode != prev_mode);

    always_ff @(posedge clk1ms or negedge rst) begin
        if (!rst) begin
            prev_mode <= MODE_BREATHE;
        end else if (en) begin
            prev_mode <= mode;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        breath_chan #(
            .BITS   (BITS),
            .RANGE  (RANGE),
            .STEP_W (STEP_W),
            .HOLD_W (HOLD_W),
            .RELOAD (i * STAGGER)
        ) u_chan (
            .clk1ms     (clk1ms),
            .rst        (rst),
            .en         (en),
            .restart    (restart),
            .mode       (mode),
            .step       (step),
            .hold       (hold),
            .duty       (duty[i*BITS +: BITS]),
            .cycle_done (cycle_done[i])
        );
    end

endmodule
